sigma_delta_decimator: RTL
==========================

// Module: sigma_delta_decimator
// PURPOSE
//  Receive end of the 1-bit sigma-delta link: turns the modulator bitstream back into signed PCM.
//  Structure: ORDER-stage CIC decimator (integrators at bit rate, decimate by R=2**LOG2_R,
//  combs at sample rate), then scaling and saturation to BW bits.
//  Used for DAC loopback checking and as the front end of the sigma-delta ADC path.
// PARAMETERS
//  BW      16  output sample width, signed two's complement
//  ORDER   3   CIC order, legal 1..4
//  LOG2_R  5   log2 of the decimation ratio (R=32)
// PORTS
//  clk             in   1       clock, single domain
//  rst_n_i         in   1       asynchronous reset, active low
//  clear_i         in   1       synchronous clear of the whole datapath
//  bit_valid_i     in   1       bit_i is accepted this cycle
//  bit_i           in   1       modulator bit: 0 -> +1, 1 -> -1 (1 = negative sign bit)
//  sample_o        out  BW      decimated PCM sample, signed
//  sample_valid_o  out  1       one-cycle strobe, sample_o is valid
//  sat_o           out  1       sample_o was clipped; qualified by sample_valid_o
// BEHAVIOUR
//  Reset (rst_n_i=0, async): clears all integrators, comb delay registers, decim_cnt and warm_cnt.
//   sample_o=0, sample_valid_o=0, sat_o=0. clear_i=1 has the same effect at the next edge.
//   clear_i takes priority over bit_valid_i; the bit presented with clear_i is discarded.
//  Internal width W = ORDER*LOG2_R+2, signed. Integrators wrap modulo 2**W; this wrap is intended.
//   CIC arithmetic is exact under wrap.
//  Integrators: on each edge with bit_valid_i=1, int[0]+=x (x=+1/-1); int[k]+=int[k-1] for k>0,
//   using old values (registered chain). No change when bit_valid_i=0.
//  decim_cnt counts accepted bits 0..R-1 and wraps. An accepted bit with decim_cnt==R-1 sets
//   dec_stb for the next cycle.
//  Comb: in the cycle where dec_stb=1, c[0]=int[ORDER-1] and c[k]=c[k-1]-dly[k-1].
//   dly[k] is updated with c[k] at that edge. Combs are combinational within the cycle;
//   the delay registers only update on dec_stb.
//  Scaling: full scale +/-R**ORDER maps to +/-2**(BW-1). Let SH = BW-1-ORDER*LOG2_R.
//   SH>=0: left shift by SH. SH<0: arithmetic right shift, truncating toward -inf.
//   Results above 2**(BW-1)-1 clip to 2**(BW-1)-1 with sat_o=1.
//   -2**(BW-1) is representable and does not saturate.
//  Latency: sample_o and sample_valid_o are registered at the edge that ends the dec_stb cycle.
//   sample_valid_o is high 2 cycles after the cycle in which the R-th bit of a frame was accepted.
//   sample_o holds its value between strobes.
//  Warm-up: warm_cnt suppresses sample_valid_o for the first ORDER decimated outputs after reset
//   or clear. sample_o still updates during warm-up. warm_cnt saturates at ORDER.
//  bit_valid_i may stall at any time, including mid-frame; integrator and counter state is held.
//  Throughput: one bit per cycle at most, one sample per R accepted bits.
// STRUCTURE
//  Shared package sdm_pkg holds:
//   - bit mapping constants SDM_BIT_POS=1'b0, SDM_BIT_NEG=1'b1 (shared with the modulator)
//   - function cic_width(order, log2_r) returning W
//  Sub-module cic_integrator_stage (W-bit accumulator with enable and sync clear), instantiated
//   ORDER times via generate.
//  Comb chain, decimation counter, warm-up counter and output scaling stay in this module.
//  Elaboration check: ORDER in 1..4 and LOG2_R>=1; fail the build otherwise.
// TESTING (defaults: BW=16, ORDER=3, R=32, bit_valid_i=1 unless noted)
//  1 Constant bit_i=0 -> first valid after 128 accepted bits; sample_o=32767, sat_o=1 every sample.
//  2 Constant bit_i=1 -> sample_o=-32768 (0x8000), sat_o=0; valid strobes exactly 32 cycles apart.
//  3 Alternating 0,1 -> sample_o=0 on every valid sample. Pattern 0,0,0,1 repeating -> 16384.
//  4 bit_valid_i high 1 cycle in 4, constant 0 -> same values as case 1; strobes 128 cycles apart;
//    sample_valid_o pulse is 1 cycle wide.
//  5 clear_i for 1 cycle mid-frame (bit 17), with bit_valid_i=1 -> that bit is dropped; no valid
//    for the next 96 accepted bits; first valid 2 cycles after the 128th accepted bit.
//  6 rst_n_i low asynchronously mid-frame, between edges -> all outputs 0 immediately.
//    After release, behaviour is identical to a fresh start (case 1 timing).
//  Bench also drives the dac_sigma_delta modulator into this block with a DC input of 8192.
//  Mean of sample_o after warm-up must be within +/-64 LSB of 8192 * sign convention.

Source files
------------

// File: rtl/sdm_pkg.sv
// Shared sigma-delta definitions: bitstream polarity and CIC register width.
package sdm_pkg;
  localparam logic SDM_BIT_POS = 1'b0;
  localparam logic SDM_BIT_NEG = 1'b1;

  // Growth of ORDER*LOG2_R bits plus sign, plus one so +R**ORDER is representable.
  function automatic int cic_width(input int order, input int log2_r);
    return order * log2_r + 2;
  endfunction
endpackage

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: W-bit wrapping accumulator with enable and synchronous clear.
module cic_integrator_stage #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc + din;
  end
endmodule

// File: rtl/sigma_delta_decimator.sv
// CIC decimator for the 1-bit sigma-delta link: integrators at bit rate, combs at
// sample rate, then scaling and saturation to a BW-bit signed PCM sample.
module sigma_delta_decimator
  import sdm_pkg::*;
#(
  parameter int BW     = 16,
  parameter int ORDER  = 3,
  parameter int LOG2_R = 5
) (
  input  logic                 clk,
  input  logic                 rst_n_i,
  input  logic                 clear_i,
  input  logic                 bit_valid_i,
  input  logic                 bit_i,
  output logic signed [BW-1:0] sample_o,
  output logic                 sample_valid_o,
  output logic                 sat_o
);
  localparam int W  = cic_width(ORDER, LOG2_R);
  localparam int SH = BW - 1 - ORDER * LOG2_R;
  localparam int SW = (SH > 0) ? W + SH : W;
  localparam logic [2:0] WARM_MAX = 3'(ORDER);
  localparam logic signed [SW-1:0] MAXV = {{(SW-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  if (ORDER < 1 || ORDER > 4 || LOG2_R < 1) begin : g_bad_param
    $error("sigma_delta_decimator: ORDER must be 1..4 and LOG2_R >= 1");
  end

  logic                    accept;
  logic [W-1:0]            x;
  logic [ORDER-1:0][W-1:0] int_in, int_q;

  assign accept = bit_valid_i & ~clear_i;
  assign x      = (bit_i == SDM_BIT_NEG) ? {W{1'b1}} : W'(1);

  // Registered chain: each stage adds the previous stage's old value.
  for (genvar g = 0; g < ORDER; g++) begin : g_int
    if (g == 0) begin : g_first
      assign int_in[g] = x;
    end else begin : g_next
      assign int_in[g] = int_q[g-1];
    end
    cic_integrator_stage #(.W(W)) u_int (
      .clk   (clk),
      .rst_n (rst_n_i),
      .clear (clear_i),
      .en    (accept),
      .din   (int_in[g]),
      .acc   (int_q[g])
    );
  end

  logic [LOG2_R-1:0]       decim_cnt;
  logic                    dec_stb;
  logic [2:0]              warm_cnt;
  logic [ORDER-1:0][W-1:0] dly, c_tap;
  logic signed [W-1:0]     comb_out;

  always_comb begin
    logic [W-1:0] acc;
    acc   = int_q[ORDER-1];
    c_tap = '0;
    for (int k = 0; k < ORDER; k++) begin
      c_tap[k] = acc;
      acc      = acc - dly[k];
    end
    comb_out = acc;
  end

  logic signed [SW-1:0] scaled;
  if (SH >= 0) begin : g_shl
    assign scaled = SW'(comb_out) <<< SH;
  end else begin : g_shr
    assign scaled = comb_out >>> (-SH);
  end

  logic          sat_hi, sat_lo;
  logic [BW-1:0] clipped;
  assign sat_hi  = scaled > MAXV;
  assign sat_lo  = scaled < MINV;
  assign clipped = sat_hi ? MAXV[BW-1:0] : (sat_lo ? MINV[BW-1:0] : scaled[BW-1:0]);

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      decim_cnt      <= '0;
      dec_stb        <= 1'b0;
      warm_cnt       <= '0;
      dly            <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      sat_o          <= 1'b0;
    end else if (clear_i) begin
      decim_cnt      <= '0;
      dec_stb        <= 1'b0;
      warm_cnt       <= '0;
      dly            <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      sat_o          <= 1'b0;
    end else begin
      dec_stb        <= accept && (decim_cnt == {LOG2_R{1'b1}});
      sample_valid_o <= 1'b0;
      if (accept) decim_cnt <= decim_cnt + 1'b1;
      // sample_o tracks every decimated output; only the strobe is held off in warm-up.
      if (dec_stb) begin
        dly      <= c_tap;
        sample_o <= clipped;
        sat_o    <= sat_hi | sat_lo;
        if (warm_cnt == WARM_MAX) sample_valid_o <= 1'b1;
        else                      warm_cnt       <= warm_cnt + 1'b1;
      end
    end
  end
endmodule
